// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, jump, PC-relative branch,
// call/return through an external return-address stack, stall and halt.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | normal fetch; one request serviced per cycle by priority
// ST_RET_WAIT | pop strobe high; stack presents jl, PC loads it next edge
// ST_HALT   | PC frozen, no stack traffic, waits for resume
module pc_sequencer #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter int                STACK_DEPTH = 32
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              call,
  input  logic              ret,
  input  logic [31:0]       jl,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] end_atual,
  output logic              push,
  output logic              pop,
  output logic              halted,
  output logic [5:0]        depth,
  output logic              stack_err
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [5:0] DEPTH_MAX = 6'(STACK_DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_branch;
  logic [5:0]        depth_nxt;
  logic              pop_nxt;
  logic              err_nxt;
  logic              stack_empty;
  logic              stack_full;

  // Only the low ADDR_W bits of the popped word carry the return address.
  generate
    if (ADDR_W < 32) begin : g_jl_unused
      logic unused_jl_hi;
      assign unused_jl_hi = ^jl[31:ADDR_W];
    end
  endgenerate

  // Both sums wrap modulo 2^ADDR_W; the offset is two's complement, so a
  // plain add of equal-width operands gives the signed result.
  assign pc_inc      = end_atual + ADDR_W'(1);
  assign pc_branch   = pc_inc + branch_offset;
  assign stack_empty = (depth == 6'd0);
  assign stack_full  = (depth == DEPTH_MAX);
  assign halted      = (state == ST_HALT);

  // Next-state, next-PC and strobe decode; push is combinational so the
  // stack can capture end_atual+1 on the falling edge of this same cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = end_atual;
    depth_nxt = depth;
    pop_nxt   = 1'b0;
    err_nxt   = stack_err;
    push      = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (halt_req) begin
          state_nxt = ST_HALT;
        end else if (stall) begin
          pc_nxt = end_atual;
        end else if (ret) begin
          if (stack_empty) begin
            err_nxt = 1'b1;
            pc_nxt  = pc_inc;
          end else begin
            pop_nxt   = 1'b1;
            state_nxt = ST_RET_WAIT;
          end
        end else if (call) begin
          if (stack_full) begin
            err_nxt = 1'b1;
            pc_nxt  = pc_inc;
          end else begin
            push      = 1'b1;
            depth_nxt = depth + 6'd1;
            pc_nxt    = jump_target;
          end
        end else if (jump) begin
          pc_nxt = jump_target;
        end else if (branch && branch_taken) begin
          pc_nxt = pc_branch;
        end else begin
          pc_nxt = pc_inc;
        end
      end
      ST_RET_WAIT: begin
        pc_nxt    = jl[ADDR_W-1:0];
        depth_nxt = depth - 6'd1;
        state_nxt = ST_RUN;
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    // A push during reset would corrupt a stack that is about to be
    // considered empty.
    if (reset) begin
      push = 1'b0;
    end
  end

  // State, PC, occupancy and flag registers with synchronous reset.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state     <= ST_RUN;
      end_atual <= RESET_ADDR;
      depth     <= 6'd0;
      pop       <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      end_atual <= pc_nxt;
      depth     <= depth_nxt;
      pop       <= pop_nxt;
      stack_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver advances a behavioural model
// and queues the expected outputs of each cycle; a monitor compares them on
// the falling edge. A separate process emulates the return-address stack.
module tb_pc_sequencer;

  localparam int DEPTH = 32;

  logic        sys_clock;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        call;
  logic        ret;
  logic [31:0] jl;
  logic        halt_req;
  logic        resume;
  logic [15:0] end_atual;
  logic        push;
  logic        pop;
  logic        halted;
  logic [5:0]  depth;
  logic        stack_err;

  pc_sequencer #(.ADDR_W(16), .RESET_ADDR(16'h0000), .STACK_DEPTH(DEPTH)) dut (
    .sys_clock(sys_clock), .reset(reset), .stall(stall), .jump(jump),
    .jump_target(jump_target), .branch(branch), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .call(call), .ret(ret), .jl(jl),
    .halt_req(halt_req), .resume(resume), .end_atual(end_atual), .push(push),
    .pop(pop), .halted(halted), .depth(depth), .stack_err(stack_err)
  );

  typedef struct {
    logic [15:0] pc;
    logic        push;
    logic        pop;
    logic        halted;
    logic [5:0]  depth;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   armed = 0;

  // Reference model state
  logic [15:0] m_pc;
  int          m_depth;
  bit          m_err;
  bit          m_halt;
  bit          m_retw;
  logic [15:0] m_ret_addr;
  logic [15:0] ref_stack[$];

  // Emulated return-address stack driven by the DUT strobes
  logic [15:0] emu_stack[$];

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  always @(negedge sys_clock) begin
    logic [15:0] r;
    logic [15:0] hi;
    if (push) emu_stack.push_back(end_atual + 16'd1);
    if (pop) begin
      if (emu_stack.size() > 0) r = emu_stack.pop_back();
      else r = 16'hDEAD;
      hi = 16'($urandom);
      jl = {hi, r};
    end
    if (reset) emu_stack.delete();
  end

  always @(negedge sys_clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (end_atual !== e.pc || push !== e.push || pop !== e.pop ||
          halted !== e.halted || depth !== e.depth || stack_err !== e.err) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t: got pc=%h push=%b pop=%b halted=%b depth=%0d err=%b, expected pc=%h push=%b pop=%b halted=%b depth=%0d err=%b",
                 $time, end_atual, push, pop, halted, depth, stack_err,
                 e.pc, e.push, e.pop, e.halted, e.depth, e.err);
      end
    end
  end

  task automatic model_step();
    int tmp;
    if (reset) begin
      m_pc = 16'h0000; m_depth = 0; m_err = 0; m_halt = 0; m_retw = 0;
      ref_stack.delete();
    end else if (m_retw) begin
      m_pc = m_ret_addr; m_depth--; m_retw = 0;
    end else if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (halt_req) begin
      m_halt = 1;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_depth == 0) begin
        m_err = 1; m_pc = m_pc + 16'd1;
      end else begin
        m_ret_addr = ref_stack.pop_back(); m_retw = 1;
      end
    end else if (call) begin
      if (m_depth == DEPTH) begin
        m_err = 1; m_pc = m_pc + 16'd1;
      end else begin
        ref_stack.push_back(m_pc + 16'd1); m_depth++; m_pc = jump_target;
      end
    end else if (jump) begin
      m_pc = jump_target;
    end else if (branch && branch_taken) begin
      tmp  = int'(m_pc) + 1 + int'($signed(branch_offset));
      m_pc = tmp[15:0];
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  // Queue what this cycle should show, advance the model, move to next cycle.
  task automatic tick();
    exp_t e;
    e.pc     = m_pc;
    e.pop    = m_retw;
    e.halted = m_halt;
    e.depth  = 6'(m_depth);
    e.err    = m_err;
    e.push   = !reset && !m_halt && !m_retw && !halt_req && !stall && !ret &&
               call && (m_depth < DEPTH);
    if (armed) exp_q.push_back(e);
    model_step();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; jump = 0; jump_target = 16'h0; branch = 0;
    branch_taken = 0; branch_offset = 16'h0; call = 0; ret = 0;
    halt_req = 0; resume = 0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pc_before;
    clear_inputs();
    jl = 32'h0;
    reset = 1;
    model_step();
    @(posedge sys_clock);
    #1;
    armed = 1;
    tick();
    reset = 0;
    chk("reset_pc", end_atual, 16'h0000);
    chk("reset_depth", 16'(depth), 16'd0);
    chk("reset_err", 16'(stack_err), 16'd0);

    repeat (5) tick();
    chk("free_run_pc", end_atual, 16'h0005);

    jump = 1; jump_target = 16'h0010; tick(); jump = 0;
    call = 1; jump_target = 16'h0100; tick(); call = 0;
    chk("call_pc", end_atual, 16'h0100);
    chk("call_depth", 16'(depth), 16'd1);
    ret = 1; tick(); ret = 0;
    chk("ret_pop", 16'(pop), 16'd1);
    chk("ret_pc_hold", end_atual, 16'h0100);
    tick();
    chk("ret_pc", end_atual, 16'h0011);
    chk("ret_depth", 16'(depth), 16'd0);
    chk("ret_pop_clear", 16'(pop), 16'd0);

    jump = 1; jump_target = 16'h0020; tick(); jump = 0;
    branch = 1; branch_taken = 1; branch_offset = 16'hFFFE; tick();
    branch = 0; branch_taken = 0;
    chk("branch_back", end_atual, 16'h001F);
    jump = 1; jump_target = 16'h0020; tick(); jump = 0;
    branch = 1; branch_offset = 16'h0040; tick(); branch = 0;
    chk("branch_not_taken", end_atual, 16'h0021);
    jump = 1; jump_target = 16'hFFFF; tick(); jump = 0;
    tick();
    chk("pc_wrap", end_atual, 16'h0000);

    ret = 1; tick(); ret = 0;
    chk("underflow_err", 16'(stack_err), 16'd1);
    chk("underflow_pc", end_atual, 16'h0001);

    reset = 1; tick(); reset = 0;
    call = 1;
    for (int i = 0; i < DEPTH; i++) begin
      jump_target = 16'($urandom); tick();
    end
    chk("full_depth", 16'(depth), 16'd32);
    chk("full_no_err", 16'(stack_err), 16'd0);
    pc_before = end_atual;
    tick(); call = 0;
    chk("overflow_depth", 16'(depth), 16'd32);
    chk("overflow_err", 16'(stack_err), 16'd1);
    chk("overflow_pc", end_atual, pc_before + 16'd1);
    ret = 1;
    repeat (2 * DEPTH) tick();
    ret = 0;
    chk("unwind_depth", 16'(depth), 16'd0);

    jump = 1; jump_target = 16'h0005; tick(); jump = 0;
    halt_req = 1; tick(); halt_req = 0;
    jump = 1; jump_target = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      chk("halt_flag", 16'(halted), 16'd1);
      chk("halt_pc", end_atual, 16'h0005);
      tick();
    end
    jump = 0; resume = 1; tick(); resume = 0;
    chk("resume_flag", 16'(halted), 16'd0);
    chk("resume_pc", end_atual, 16'h0005);
    tick();
    chk("resume_pc_next", end_atual, 16'h0006);

    call = 1; jump_target = 16'h0040; tick(); call = 0;
    ret = 1; tick(); ret = 0;
    chk("retwait_pop", 16'(pop), 16'd1);
    reset = 1; tick(); reset = 0;
    chk("abort_pc", end_atual, 16'h0000);
    chk("abort_pop", 16'(pop), 16'd0);
    chk("abort_depth", 16'(depth), 16'd0);
    tick();
    stall = 1; call = 1; jump_target = 16'h0777;
    pc_before = end_atual;
    tick();
    stall = 0; call = 0;
    chk("stall_call_pc", end_atual, pc_before);
    chk("stall_call_depth", 16'(depth), 16'd0);

    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(299) == 0);
      stall         = ($urandom_range(7) == 0);
      jump          = ($urandom_range(5) == 0);
      jump_target   = 16'($urandom);
      branch        = ($urandom_range(3) == 0);
      branch_taken  = ($urandom_range(1) == 0);
      branch_offset = ($urandom_range(1) == 0) ? 16'($urandom_range(64)) :
                                                 16'(-$urandom_range(64));
      call          = ($urandom_range(6) == 0);
      ret           = ($urandom_range(6) == 0);
      halt_req      = ($urandom_range(39) == 0);
      resume        = ($urandom_range(3) == 0);
      tick();
    end
    clear_inputs();
    repeat (4) tick();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sys_clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the processor; drives the current instruction address to the fetch path and to the register bank's return-address stack.
- Issues push (call) and pop (return) requests to that stack and consumes the popped return address.
- Handles sequential increment, absolute jump, PC-relative branch, call/return, stall and halt/resume.
- Acts as the initiator side of the call/return stack interface.

Parameters:
- ADDR_W, 16, width of the instruction address.
- RESET_ADDR, 0, PC value loaded on reset.
- STACK_DEPTH, 32, number of return-address entries in the register-bank stack; used for overflow/underflow tracking.

Ports:
- sys_clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and suppress all requests this cycle.
- jump  input  1  absolute jump request.
- jump_target  input  ADDR_W  target for jump and call.
- branch  input  1  conditional branch instruction present.
- branch_taken  input  1  branch condition result.
- branch_offset  input  ADDR_W  signed two's-complement offset, relative to PC+1.
- call  input  1  call request; pushes PC+1 on the stack and jumps to jump_target.
- ret  input  1  return request.
- jl  input  32  popped return address from the stack; bits [ADDR_W-1:0] are used.
- halt_req  input  1  enter HALT.
- resume  input  1  leave HALT.
- end_atual  output  ADDR_W  current PC; registered.
- push  output  1  stack push strobe; combinational.
- pop  output  1  stack pop strobe; registered.
- halted  output  1  high in HALT.
- depth  output  6  current stack occupancy, 0..STACK_DEPTH.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset values:
  - end_atual=RESET_ADDR, state=RUN, pop=0, halted=0, depth=0, stack_err=0.
  - push is 0 because the state is RUN with call low.
  - A reset in any state, including RET_WAIT, aborts the operation with no further pop.
- States: RUN, RET_WAIT, HALT.
- RUN priority per cycle, highest first:
  1. halt_req: go to HALT, PC holds, no push/pop.
  2. stall: PC holds, no request.
  3. ret:
     - If depth=0: set stack_err, PC <= PC+1, stay in RUN, no pop.
     - Else: PC holds, pop <= 1, go to RET_WAIT.
  4. call:
     - If depth=STACK_DEPTH: set stack_err, PC <= PC+1, no push.
     - Else: push=1 combinationally this cycle, depth+1, PC <= jump_target.
     - The stack captures end_atual+1 on the negedge inside this cycle.
  5. jump: PC <= jump_target.
  6. branch && branch_taken: PC <= PC+1+branch_offset, mod 2^ADDR_W.
  7. Otherwise, including a not-taken branch: PC <= PC+1.
- RET_WAIT:
  - pop=1 for exactly this one cycle; the stack updates jl on the negedge inside it.
  - Next posedge: PC <= jl[ADDR_W-1:0], depth-1, pop <= 0, go to RUN.
  - stall, halt_req and all other requests are ignored in RET_WAIT.
  - Return latency: 2 cycles from ret to the new PC.
- HALT:
  - halted=1, PC holds, push=0, pop=0.
  - resume: go to RUN next cycle; the PC resumes from the held value.
  - halt_req is ignored in HALT.
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W.
  - 0xFFFF+1 wraps to 0x0000.
  - The offset is sign-interpreted: 0xFFFE means -2.
- stack_err clears only on reset.
- push and pop are never high in the same cycle.

Test Plan:
- Reset, then 4 free-run cycles -> end_atual 0,1,2,3,4; push=pop=0; depth=0.
- At PC=0x0010, call with jump_target=0x0100 -> push=1 in that cycle with end_atual=0x0010; next PC=0x0100; depth=1. Then ret -> pop=1 for one cycle; after 2 cycles PC=jl=0x0011; depth=0.
- At PC=0x0020, branch_taken with offset=0xFFFE -> next PC=0x001F. Branch not taken -> PC=0x0021. At PC=0xFFFF with no request -> PC=0x0000.
- ret at depth=0 -> stack_err=1, pop stays 0, PC+1. Fill STACK_DEPTH calls, then one more call -> push=0, stack_err=1, depth stays 32.
- halt_req at PC=0x0005 -> halted=1 and PC holds 0x0005 for 3 cycles while jump is asserted. resume -> PC 0x0006 on the cycle after returning to RUN.
- ret issued, then reset asserted during RET_WAIT -> next cycle PC=RESET_ADDR, pop=0, depth=0, state RUN. Stall together with call -> no push, PC held.
